// File: rtl/vscale_hazard_scoreboard.sv
// Hazard/bypass scoreboard for a deeper vscale pipeline. It tracks pending register writes across
// the post-issue stages, picks a forwarding stage for each source, stalls on not-yet-ready load data
// and counts the cycles lost to hazards.
module vscale_hazard_scoreboard #(
    parameter  int NUM_STAGES     = 2,
    parameter  int LOAD_LATENCY   = 1,
    parameter  int NUM_SRC        = 2,
    parameter  int REG_ADDR_WIDTH = 5,
    parameter  int CNT_WIDTH      = 32,
    localparam int SEL_W          = $clog2(NUM_STAGES + 1)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              advance,
    input  logic [NUM_STAGES-1:0]             flush_mask,
    input  logic                              issue_valid,
    input  logic                              issue_wr_reg,
    input  logic                              issue_is_load,
    input  logic [REG_ADDR_WIDTH-1:0]         issue_rd,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] issue_rs_addr,
    input  logic [NUM_SRC-1:0]                issue_uses_rs,
    output logic [NUM_SRC*SEL_W-1:0]          bypass_sel,
    output logic                              stall_issue,
    output logic                              wb_valid,
    output logic [REG_ADDR_WIDTH-1:0]         wb_rd,
    output logic [CNT_WIDTH-1:0]              stall_cnt
);

    // Index k-1 holds the entry for stage k (stage 1 is the youngest).
    logic [NUM_STAGES-1:0]                     valid_q, valid_d;
    logic [NUM_STAGES-1:0]                     load_q, load_d;
    logic [NUM_STAGES-1:0][REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [CNT_WIDTH-1:0]                      stall_cnt_q, stall_cnt_d;
    logic                                      hazard;

    // Stages are scanned oldest to youngest so the youngest match overwrites any older one.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path can infer a latch.
        bypass_sel = '0;
        hazard     = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            logic [REG_ADDR_WIDTH-1:0] rs;
            logic [SEL_W-1:0]          sel;
            logic                      haz_i;
            rs    = issue_rs_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            sel   = '0;
            haz_i = 1'b0;
            for (int k = NUM_STAGES; k >= 1; k--) begin
                if (issue_valid && issue_uses_rs[i] && (rs != '0) && valid_q[k-1] &&
                    (rd_q[k-1] == rs) && !flush_mask[k-1]) begin
                    if (!load_q[k-1] || (k >= LOAD_LATENCY)) begin
                        sel   = SEL_W'(k);
                        haz_i = 1'b0;
                    end else begin
                        sel   = '0;
                        haz_i = 1'b1;
                    end
                end
            end
            bypass_sel[i*SEL_W +: SEL_W] = sel;
            hazard = hazard | haz_i;
        end
    end

    always_comb begin
        valid_d = valid_q & ~flush_mask;
        rd_d    = rd_q;
        load_d  = load_q;
        if (advance) begin
            for (int k = NUM_STAGES - 1; k >= 1; k--) begin
                valid_d[k] = valid_q[k-1] & ~flush_mask[k-1];
                rd_d[k]    = rd_q[k-1];
                load_d[k]  = load_q[k-1];
            end
            // A hazard leaves a bubble in stage 1; x0 writes are never tracked.
            valid_d[0] = issue_valid & issue_wr_reg & ~hazard & (issue_rd != '0);
            rd_d[0]    = issue_rd;
            load_d[0]  = issue_is_load;
        end
        stall_cnt_d = stall_cnt_q;
        if (hazard && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= '0;
            load_q      <= '0;
            rd_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: state registers take non-blocking assignments so every stage shifts from old values.
            valid_q     <= valid_d;
            load_q      <= load_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_issue = hazard | ~advance;
    assign wb_valid    = valid_q[NUM_STAGES-1] & ~flush_mask[NUM_STAGES-1];
    assign wb_rd       = wb_valid ? rd_q[NUM_STAGES-1] : '0;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_vscale_hazard_scoreboard.sv
// Bench for vscale_hazard_scoreboard (2 stages, load data bypassable from stage 2, 3-bit counter):
// a vector table plus hand sequences for counter saturation and mid-stream reset.
module tb_vscale_hazard_scoreboard;

    localparam int NS  = 2;
    localparam int RAW = 5;
    localparam int CW  = 3;

    typedef struct {
        logic           adv;
        logic [1:0]     flush;
        logic           iv, wr, ld;
        logic [RAW-1:0] rd, rs0, rs1;
        logic [1:0]     uses;
        logic [1:0]     e_sel0, e_sel1;
        logic           e_stall, e_wbv;
        logic [RAW-1:0] e_wbrd;
        logic [CW-1:0]  e_cnt;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            advance;
    logic [NS-1:0]   flush_mask;
    logic            issue_valid, issue_wr_reg, issue_is_load;
    logic [RAW-1:0]  issue_rd;
    logic [2*RAW-1:0] issue_rs_addr;
    logic [1:0]      issue_uses_rs;
    logic [3:0]      bypass_sel;
    logic            stall_issue, wb_valid;
    logic [RAW-1:0]  wb_rd;
    logic [CW-1:0]   stall_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    vscale_hazard_scoreboard #(
        .NUM_STAGES(NS), .LOAD_LATENCY(2), .NUM_SRC(2), .REG_ADDR_WIDTH(RAW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .advance(advance), .flush_mask(flush_mask),
        .issue_valid(issue_valid), .issue_wr_reg(issue_wr_reg), .issue_is_load(issue_is_load),
        .issue_rd(issue_rd), .issue_rs_addr(issue_rs_addr), .issue_uses_rs(issue_uses_rs),
        .bypass_sel(bypass_sel), .stall_issue(stall_issue), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic adv, input logic [1:0] flush, input logic iv,
                                input logic wr, input logic ld, input logic [RAW-1:0] rd,
                                input logic [RAW-1:0] rs0, input logic [RAW-1:0] rs1,
                                input logic [1:0] uses, input logic [1:0] sel0,
                                input logic [1:0] sel1, input logic stall, input logic wbv,
                                input logic [RAW-1:0] wbrd, input logic [CW-1:0] cnt);
        vec_t v;
        v.adv = adv; v.flush = flush; v.iv = iv; v.wr = wr; v.ld = ld;
        v.rd = rd; v.rs0 = rs0; v.rs1 = rs1; v.uses = uses;
        v.e_sel0 = sel0; v.e_sel1 = sel1; v.e_stall = stall; v.e_wbv = wbv;
        v.e_wbrd = wbrd; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        advance       = v.adv;
        flush_mask    = v.flush;
        issue_valid   = v.iv;
        issue_wr_reg  = v.wr;
        issue_is_load = v.ld;
        issue_rd      = v.rd;
        issue_rs_addr = {v.rs1, v.rs0};
        issue_uses_rs = v.uses;
    endtask

    // Drive on the falling edge, queue the expectation, compare 2 ns later, well before the rising edge.
    task automatic apply(input string tag, input vec_t v);
        vec_t e;
        @(negedge clk);
        drive(v);
        exp_q.push_back(v);
        #2;
        e = exp_q.pop_front();
        check({tag, " sel0"},  32'(bypass_sel[1:0]), 32'(e.e_sel0));
        check({tag, " sel1"},  32'(bypass_sel[3:2]), 32'(e.e_sel1));
        check({tag, " stall"}, 32'(stall_issue),     32'(e.e_stall));
        check({tag, " wbv"},   32'(wb_valid),        32'(e.e_wbv));
        check({tag, " wbrd"},  32'(wb_rd),           32'(e.e_wbrd));
        check({tag, " cnt"},   32'(stall_cnt),       32'(e.e_cnt));
    endtask

    initial begin
        vec_t idle;
        idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //          adv flush iv wr ld rd  rs0 rs1 uses  sel0 sel1 stl wbv wbrd cnt
        vecs.push_back(mk(1, 2'b00, 0, 0, 0,  0,  0,  0, 2'b00, 0, 0, 0, 0,  0, 0)); // idle
        vecs.push_back(mk(1, 2'b00, 1, 1, 0,  5,  0,  0, 2'b00, 0, 0, 0, 0,  0, 0)); // add x5
        vecs.push_back(mk(1, 2'b00, 1, 1, 0, 10,  5,  0, 2'b01, 1, 0, 0, 0,  0, 0)); // use x5 at stage 1
        vecs.push_back(mk(1, 2'b00, 1, 0, 0,  0,  5, 10, 2'b11, 2, 1, 0, 1,  5, 0)); // both sources forwarded
        vecs.push_back(mk(1, 2'b00, 1, 1, 1,  6,  0,  0, 2'b00, 0, 0, 0, 1, 10, 0)); // lw x6
        vecs.push_back(mk(1, 2'b00, 1, 1, 0, 11,  0,  6, 2'b10, 0, 0, 1, 0,  0, 0)); // load-use stall
        vecs.push_back(mk(1, 2'b00, 1, 1, 0, 11,  0,  6, 2'b10, 0, 2, 0, 1,  6, 1)); // retry forwards stage 2
        vecs.push_back(mk(1, 2'b00, 1, 1, 0,  7,  0,  0, 2'b00, 0, 0, 0, 0,  0, 1)); // add x7
        vecs.push_back(mk(1, 2'b00, 1, 1, 0,  7,  0,  0, 2'b00, 0, 0, 0, 1, 11, 1)); // add x7 again
        vecs.push_back(mk(1, 2'b00, 1, 0, 0,  0,  7,  7, 2'b01, 1, 0, 0, 1,  7, 1)); // youngest wins, src1 unused
        vecs.push_back(mk(1, 2'b00, 1, 1, 1,  8,  0,  0, 2'b00, 0, 0, 0, 1,  7, 1)); // lw x8
        vecs.push_back(mk(1, 2'b01, 1, 0, 0,  0,  8,  0, 2'b01, 0, 0, 0, 0,  0, 1)); // flushed stage 1 ignored
        vecs.push_back(mk(1, 2'b00, 0, 0, 0,  0,  0,  0, 2'b00, 0, 0, 0, 0,  0, 1)); // flushed entry not retired
        vecs.push_back(mk(1, 2'b00, 1, 1, 1,  0,  0,  0, 2'b00, 0, 0, 0, 0,  0, 1)); // lw x0
        vecs.push_back(mk(1, 2'b00, 1, 0, 0,  0,  0,  0, 2'b11, 0, 0, 0, 0,  0, 1)); // x0 never tracked
        vecs.push_back(mk(1, 2'b00, 1, 1, 0,  9,  0,  0, 2'b00, 0, 0, 0, 0,  0, 1)); // add x9
        vecs.push_back(mk(0, 2'b00, 1, 1, 0, 12,  9,  0, 2'b01, 1, 0, 1, 0,  0, 1)); // hold 1
        vecs.push_back(mk(0, 2'b00, 1, 1, 0, 12,  9,  0, 2'b01, 1, 0, 1, 0,  0, 1)); // hold 2
        vecs.push_back(mk(0, 2'b00, 1, 1, 0, 12,  9,  0, 2'b01, 1, 0, 1, 0,  0, 1)); // hold 3
        vecs.push_back(mk(1, 2'b00, 0, 0, 0,  0,  0,  0, 2'b00, 0, 0, 0, 0,  0, 1)); // release
        vecs.push_back(mk(1, 2'b00, 0, 0, 0,  0,  0,  0, 2'b00, 0, 0, 0, 1,  9, 1)); // x9 retires
        vecs.push_back(mk(1, 2'b00, 1, 1, 0, 13,  0,  0, 2'b00, 0, 0, 0, 0,  0, 1)); // add x13
        vecs.push_back(mk(0, 2'b01, 0, 0, 0,  0,  0,  0, 2'b00, 0, 0, 1, 0,  0, 1)); // flush while held
        vecs.push_back(mk(1, 2'b00, 0, 0, 0,  0,  0,  0, 2'b00, 0, 0, 0, 0,  0, 1));
        vecs.push_back(mk(1, 2'b00, 0, 0, 0,  0,  0,  0, 2'b00, 0, 0, 0, 0,  0, 1)); // x13 gone
        vecs.push_back(mk(1, 2'b00, 1, 1, 0, 14,  0,  0, 2'b00, 0, 0, 0, 0,  0, 1)); // add x14
        vecs.push_back(mk(1, 2'b00, 0, 0, 0,  0,  0,  0, 2'b00, 0, 0, 0, 0,  0, 1));
        vecs.push_back(mk(1, 2'b10, 1, 0, 0,  0, 14,  0, 2'b01, 0, 0, 0, 0,  0, 1)); // flushed stage 2
        vecs.push_back(mk(1, 2'b00, 1, 1, 1, 15,  0,  0, 2'b00, 0, 0, 0, 0,  0, 1)); // lw x15

        reset_n = 1'b0;
        drive(idle);
        #12;
        check("reset sel",   32'(bypass_sel),  32'h0);
        check("reset stall", 32'(stall_issue), 32'h0);
        check("reset wbv",   32'(wb_valid),    32'h0);
        check("reset wbrd",  32'(wb_rd),       32'h0);
        check("reset cnt",   32'(stall_cnt),   32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[n]) apply($sformatf("v%0d", n), vecs[n]);

        // x15 load held in stage 1 keeps the hazard alive; the counter must stop at 7.
        for (int c = 0; c < 10; c++) begin
            int exp_cnt;
            exp_cnt = (c + 1 > 7) ? 7 : c + 1;
            apply($sformatf("sat%0d", c),
                  mk(0, 0, 1, 1, 0, 16, 15, 0, 2'b01, 0, 0, 1, 0, 0, CW'(exp_cnt)));
        end
        apply("sat_hold", mk(0, 0, 1, 1, 0, 16, 15, 0, 2'b01, 0, 0, 1, 0, 0, 7));

        // Asynchronous reset between edges clears the counter and every entry at once.
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst cnt",   32'(stall_cnt),   32'h0);
        check("midrst sel",   32'(bypass_sel),  32'h0);
        check("midrst stall", 32'(stall_issue), 32'h1);
        check("midrst wbv",   32'(wb_valid),    32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        apply("postrst", mk(1, 0, 1, 0, 0, 0, 15, 0, 2'b01, 0, 0, 0, 0, 0, 0));

        check("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
